isolde_xif_commit_buffer: RTL and testbench
===========================================

// Module: isolde_xif_commit_buffer
// PURPOSE
//  Coprocessor-side stage directly behind the XIF issue/commit channels. Buffers accepted offloaded
//  instructions with their operands until the CPU commits or kills them. Forwards committed entries,
//  in issue order, to the execution unit over a valid/ready port. Killed entries are dropped silently.
// PARAMETERS
//  X_ID_WIDTH   4   width of instruction ID (matches XIF)
//  X_NUM_RS     2   number of register source operands
//  X_RFR_WIDTH  32  width of each source operand
//  DEPTH        4   buffer entries; power of 2, >=2
// PORTS
//  clk_i               in   1                     clock
//  rst_ni              in   1                     asynchronous active-low reset
//  issue_valid_i       in   1                     XIF issue_valid
//  issue_ready_o       out  1                     XIF issue_ready
//  issue_instr_i       in   32                    offloaded instruction
//  issue_id_i          in   X_ID_WIDTH            instruction ID
//  issue_rs_i          in   X_NUM_RS*X_RFR_WIDTH  source operands; rs[k] at [k*X_RFR_WIDTH +: X_RFR_WIDTH]
//  issue_rs_valid_i    in   X_NUM_RS              operand validity
//  issue_accept_i      in   1                     decoder accept decision for issue_instr_i (combinational)
//  issue_accept_o      out  1                     XIF issue_resp.accept
//  commit_valid_i      in   1                     XIF commit_valid
//  commit_id_i         in   X_ID_WIDTH            commit.id
//  commit_kill_i       in   1                     commit.commit_kill
//  out_valid_o         out  1                     committed instruction available
//  out_ready_i         in   1                     execution unit takes head
//  out_instr_o         out  32                    head instruction
//  out_id_o            out  X_ID_WIDTH            head ID
//  out_rs_o            out  X_NUM_RS*X_RFR_WIDTH  head operands
//  count_o             out  $clog2(DEPTH+1)       occupied entries, including uncommitted and killed
//  unexp_commit_o      out  1                     sticky: commit_id matched no live entry
// BEHAVIOUR
//  Reset
//   - All entries invalid.
//   - Head/tail pointers = 0.
//   - issue_ready_o = 0 while rst_ni low.
//   - All other outputs = 0.
//  Entry fields: valid, committed, killed, instr, id, rs.
//  Issue handshake
//   - issue_ready_o = (count_o < DEPTH) & (&issue_rs_valid_i).
//   - Issue handshake occurs when issue_valid_i & issue_ready_o.
//   - issue_accept_o = issue_accept_i & issue_ready_o.
//   - If a handshake occurs with issue_accept_i=1: write entry at tail, tail++ (mod DEPTH), committed=killed=0.
//   - If a handshake occurs with issue_accept_i=0: no allocation.
//  Commit
//   - When commit_valid_i, the block looks up the live, uncommitted entry with id == commit_id_i.
//   - On a match, it sets committed=1 and killed=commit_kill_i.
//   - With no match, it sets unexp_commit_o=1; unexp_commit_o is cleared only by reset.
//   - Same-cycle issue and commit of the same ID: the new entry is written with committed=1 and
//     killed=commit_kill_i. This case does not set unexp_commit_o.
//  Head output
//   - out_valid_o = head.valid & head.committed & ~head.killed.
//   - out_instr_o, out_id_o and out_rs_o are driven from head registers. They stay stable while
//     out_valid_o & ~out_ready_i.
//   - Pop: on out_valid_o & out_ready_i, or unconditionally when head.valid & head.killed.
//   - Pop action: head.valid=0, head++ (mod DEPTH).
//   - At most one pop per cycle, so a killed head costs one cycle.
//  Latency
//   - An entry issued and committed in cycle N appears on out_valid_o in cycle N+1 if the buffer
//     was empty. There is no combinational path from issue to out.
//  Full/empty and simultaneous events
//   - Full: count_o == DEPTH, issue_ready_o = 0. A pop in the same cycle does not raise issue_ready_o
//     (ready is based on registered count).
//   - Simultaneous push and pop: count_o unchanged, pointers both advance.
//   - Wrap-around: pointers are log2(DEPTH) bits and wrap naturally.
//   - Commits may arrive out of order relative to the head. Younger committed entries wait behind an
//     uncommitted head.
//   - Reset mid-operation discards all entries immediately; no outputs are asserted after reset until
//     new issues arrive.
//  Assertions
//   - No two live entries share an ID.
//   - No commit is issued to an already-committed entry.
//   - count_o <= DEPTH.
// TESTING
//  - Issue id=3, rs valid, accept=1; commit id=3 kill=0 next cycle
//    -> out_valid_o after 1 cycle, out_id_o=3, count_o 1->0 on pop.
//  - Fill 4 entries (ids 0..3) with no commits -> issue_ready_o=0, count_o=4.
//    Then commit 0 and pop -> ready re-asserts the cycle after.
//  - Issue ids 1,2; commit 2 then 1 -> out emits id 1 then 2. id 2 is held while head is uncommitted.
//  - Issue ids 5,6; kill 5, commit 6 -> id 5 is never presented; out_id_o=6 one cycle after the kill pop.
//  - Same-cycle issue and commit of id=7 -> out_valid_o next cycle, unexp_commit_o stays 0.
//    A separate commit of id=9 with no entry -> unexp_commit_o=1.
//  - Stall out_ready_i=0 for 10 cycles with data valid -> outputs stable.
//    Assert rst_ni low mid-stream -> count_o=0, out_valid_o=0.

Source files
------------

// File: rtl/isolde_xif_commit_buffer.sv
// ----------------------------------------------------------------------------
// isolde_xif_commit_buffer
//   Holds offloaded instructions accepted on the XIF issue channel, together
//   with their source operands, until the CPU commits or kills them.
//   Committed entries leave in issue order through a valid/ready port.
//   Killed entries are retired silently, one per cycle.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   issue_*_i / issue_*_o   XIF issue handshake, operands and accept response
//   commit_*_i              XIF commit channel (id, kill)
//   out_*                   committed head towards the execution unit
//   count_o                 occupied entries, including uncommitted and killed
//   unexp_commit_o          sticky flag: a commit id matched no live entry
// ----------------------------------------------------------------------------
module isolde_xif_commit_buffer #(
  parameter int unsigned X_ID_WIDTH  = 4,
  parameter int unsigned X_NUM_RS    = 2,
  parameter int unsigned X_RFR_WIDTH = 32,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              issue_valid_i,
  output logic                              issue_ready_o,
  input  logic [31:0]                       issue_instr_i,
  input  logic [X_ID_WIDTH-1:0]             issue_id_i,
  input  logic [X_NUM_RS*X_RFR_WIDTH-1:0]   issue_rs_i,
  input  logic [X_NUM_RS-1:0]               issue_rs_valid_i,
  input  logic                              issue_accept_i,
  output logic                              issue_accept_o,
  input  logic                              commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]             commit_id_i,
  input  logic                              commit_kill_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [31:0]                       out_instr_o,
  output logic [X_ID_WIDTH-1:0]             out_id_o,
  output logic [X_NUM_RS*X_RFR_WIDTH-1:0]   out_rs_o,
  output logic [$clog2(DEPTH+1)-1:0]        count_o,
  output logic                              unexp_commit_o
);

  localparam int unsigned RS_W  = X_NUM_RS * X_RFR_WIDTH;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  // Per-entry status bits
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] cmt_q, cmt_d;
  logic [DEPTH-1:0] kill_q, kill_d;

  // Per-entry payload, written only on allocation
  logic [31:0]           instr_q [DEPTH];
  logic [X_ID_WIDTH-1:0] id_q    [DEPTH];
  logic [RS_W-1:0]       rs_q    [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             unexp_q, unexp_d;

  logic             ready_c;
  logic             alloc_c;
  logic             pop_c;
  logic             new_hit_c;
  logic [DEPTH-1:0] hit_c;

  // Ready depends only on registered occupancy, so a same-cycle pop never raises it
  assign ready_c        = rst_ni & (count_q < CNT_W'(DEPTH)) & (&issue_rs_valid_i);
  assign alloc_c        = issue_valid_i & ready_c & issue_accept_i;
  assign issue_ready_o  = ready_c;
  assign issue_accept_o = issue_accept_i & ready_c;

  // Commit lookup against live, not yet committed entries
  always_comb begin
    hit_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      hit_c[i] = valid_q[i] & ~cmt_q[i] & (id_q[i] == commit_id_i);
    end
  end

  // A commit that only matches the entry being written this cycle lands on the new entry
  assign new_hit_c = commit_valid_i & ~(|hit_c) & alloc_c & (issue_id_i == commit_id_i);

  // Killed heads retire unconditionally; committed heads wait for the consumer
  assign pop_c = valid_q[head_q] & (kill_q[head_q] | (cmt_q[head_q] & out_ready_i));

  // Next-state for status bits, pointers, occupancy and the sticky flag
  always_comb begin
    valid_d = valid_q;
    cmt_d   = cmt_q;
    kill_d  = kill_q;
    head_d  = head_q + PTR_W'(pop_c);
    tail_d  = tail_q + PTR_W'(alloc_c);
    count_d = count_q + CNT_W'(alloc_c) - CNT_W'(pop_c);
    unexp_d = unexp_q | (commit_valid_i & ~(|hit_c) & ~new_hit_c);

    if (commit_valid_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (hit_c[i]) begin
          cmt_d[i]  = 1'b1;
          kill_d[i] = commit_kill_i;
        end
      end
    end

    if (pop_c) begin
      valid_d[head_q] = 1'b0;
    end

    if (alloc_c) begin
      valid_d[tail_q] = 1'b1;
      cmt_d[tail_q]   = new_hit_c;
      kill_d[tail_q]  = new_hit_c & commit_kill_i;
    end
  end

  // Control state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      cmt_q   <= '0;
      kill_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      unexp_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      cmt_q   <= cmt_d;
      kill_q  <= kill_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      unexp_q <= unexp_d;
    end
  end

  // Payload storage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        id_q[i]    <= '0;
        rs_q[i]    <= '0;
      end
    end else if (alloc_c) begin
      instr_q[tail_q] <= issue_instr_i;
      id_q[tail_q]    <= issue_id_i;
      rs_q[tail_q]    <= issue_rs_i;
    end
  end

  assign out_valid_o    = valid_q[head_q] & cmt_q[head_q] & ~kill_q[head_q];
  assign out_instr_o    = instr_q[head_q];
  assign out_id_o       = id_q[head_q];
  assign out_rs_o       = rs_q[head_q];
  assign count_o        = count_q;
  assign unexp_commit_o = unexp_q;

  // Protocol sanity checks
  logic dup_id_c;
  logic cmt_twice_c;

  always_comb begin
    dup_id_c    = 1'b0;
    cmt_twice_c = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      for (int unsigned j = i + 1; j < DEPTH; j++) begin
        if (valid_q[i] && valid_q[j] && (id_q[i] == id_q[j])) dup_id_c = 1'b1;
      end
      if (commit_valid_i && valid_q[i] && cmt_q[i] && (id_q[i] == commit_id_i)) cmt_twice_c = 1'b1;
    end
  end

  a_unique_ids: assert property (@(posedge clk_i) disable iff (!rst_ni) !dup_id_c);
  a_no_recommit: assert property (@(posedge clk_i) disable iff (!rst_ni) !cmt_twice_c);
  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni) count_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_isolde_xif_commit_buffer.sv
module tb_isolde_xif_commit_buffer;

  localparam int unsigned IDW = 4;
  localparam int unsigned NRS = 2;
  localparam int unsigned RFW = 32;
  localparam int unsigned D   = 4;
  localparam int unsigned RSW = NRS * RFW;
  localparam int unsigned CW  = $clog2(D + 1);

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           issue_valid_i;
  logic           issue_ready_o;
  logic [31:0]    issue_instr_i;
  logic [IDW-1:0] issue_id_i;
  logic [RSW-1:0] issue_rs_i;
  logic [NRS-1:0] issue_rs_valid_i;
  logic           issue_accept_i;
  logic           issue_accept_o;
  logic           commit_valid_i;
  logic [IDW-1:0] commit_id_i;
  logic           commit_kill_i;
  logic           out_valid_o;
  logic           out_ready_i;
  logic [31:0]    out_instr_o;
  logic [IDW-1:0] out_id_o;
  logic [RSW-1:0] out_rs_o;
  logic [CW-1:0]  count_o;
  logic           unexp_commit_o;

  isolde_xif_commit_buffer #(
    .X_ID_WIDTH(IDW), .X_NUM_RS(NRS), .X_RFR_WIDTH(RFW), .DEPTH(D)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
    .issue_rs_i(issue_rs_i), .issue_rs_valid_i(issue_rs_valid_i),
    .issue_accept_i(issue_accept_i), .issue_accept_o(issue_accept_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_instr_o(out_instr_o), .out_id_o(out_id_o), .out_rs_o(out_rs_o),
    .count_o(count_o), .unexp_commit_o(unexp_commit_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: an in-order queue of outstanding instructions
  typedef struct {
    logic [31:0]    instr;
    logic [IDW-1:0] id;
    logic [RSW-1:0] rs;
    bit             committed;
    bit             killed;
  } ent_t;

  ent_t mq[$];
  bit   m_unexp;
  int   vectors     = 0;
  int   miscompares = 0;
  bit   chk_en      = 1'b0;
  logic [31:0] saved_instr;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic bit id_live(input logic [IDW-1:0] x);
    foreach (mq[i]) if (mq[i].id == x) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_unexp = 1'b0;
  endtask

  // Apply one clock edge to the model using the inputs currently driven
  task automatic model_step();
    ent_t e;
    int   hit;
    bit   rdy, alloc, pop, newc;
    if (!rst_ni) begin
      model_reset();
      return;
    end
    rdy   = (mq.size() < D) && (&issue_rs_valid_i);
    alloc = issue_valid_i && rdy && issue_accept_i;
    pop   = (mq.size() > 0) && (mq[0].killed || (mq[0].committed && out_ready_i));
    newc  = 1'b0;
    if (commit_valid_i) begin
      hit = -1;
      foreach (mq[i]) if (hit < 0 && !mq[i].committed && mq[i].id == commit_id_i) hit = i;
      if (hit >= 0) begin
        mq[hit].committed = 1'b1;
        mq[hit].killed    = commit_kill_i;
      end else if (alloc && issue_id_i == commit_id_i) begin
        newc = 1'b1;
      end else begin
        m_unexp = 1'b1;
      end
    end
    if (pop) void'(mq.pop_front());
    if (alloc) begin
      e.instr     = issue_instr_i;
      e.id        = issue_id_i;
      e.rs        = issue_rs_i;
      e.committed = newc;
      e.killed    = newc && commit_kill_i;
      mq.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  // Every-cycle comparison on the falling edge
  always @(negedge clk_i) begin
    bit exp_rdy, exp_ov;
    if (chk_en) begin
      exp_rdy = rst_ni && (mq.size() < D) && (&issue_rs_valid_i);
      exp_ov  = (mq.size() > 0) && mq[0].committed && !mq[0].killed;
      chk("issue_ready", 64'(issue_ready_o), 64'(exp_rdy));
      chk("issue_accept", 64'(issue_accept_o), 64'(issue_accept_i && exp_rdy));
      chk("count", 64'(count_o), 64'(mq.size()));
      chk("unexp", 64'(unexp_commit_o), 64'(m_unexp));
      chk("out_valid", 64'(out_valid_o), 64'(exp_ov));
      if (exp_ov) begin
        chk("out_id", 64'(out_id_o), 64'(mq[0].id));
        chk("out_instr", 64'(out_instr_o), 64'(mq[0].instr));
        chk("out_rs", out_rs_o, mq[0].rs);
      end
    end
  end

  task automatic set_idle();
    issue_valid_i    = 1'b0;
    issue_rs_valid_i = '1;
    issue_accept_i   = 1'b1;
    commit_valid_i   = 1'b0;
    commit_kill_i    = 1'b0;
    out_ready_i      = 1'b1;
  endtask

  task automatic drive_issue(input logic [IDW-1:0] id);
    issue_valid_i = 1'b1;
    issue_id_i    = id;
    issue_instr_i = $urandom;
    issue_rs_i    = {$urandom, $urandom};
  endtask

  task automatic drive_commit(input logic [IDW-1:0] id, input bit kill);
    commit_valid_i = 1'b1;
    commit_id_i    = id;
    commit_kill_i  = kill;
  endtask

  task automatic rand_drive();
    int unc[$];
    logic [IDW-1:0] fid, uid;
    bit will_alloc;
    int r;
    issue_valid_i    = ($urandom_range(0, 99) < 60);
    issue_rs_valid_i = ($urandom_range(0, 9) == 0) ? NRS'($urandom_range(0, 3)) : '1;
    issue_accept_i   = ($urandom_range(0, 9) != 0);
    do fid = IDW'($urandom_range(0, 15)); while (id_live(fid));
    issue_id_i    = fid;
    issue_instr_i = $urandom;
    issue_rs_i    = {$urandom, $urandom};
    will_alloc = issue_valid_i && (&issue_rs_valid_i) && issue_accept_i && (mq.size() < D);
    foreach (mq[i]) if (!mq[i].committed) unc.push_back(i);
    commit_valid_i = 1'b0;
    commit_kill_i  = ($urandom_range(0, 3) == 0);
    commit_id_i    = IDW'($urandom_range(0, 15));
    r = $urandom_range(0, 99);
    if (r < 40 && unc.size() > 0) begin
      commit_valid_i = 1'b1;
      commit_id_i    = mq[unc[$urandom_range(0, unc.size() - 1)]].id;
    end else if (r < 50 && will_alloc) begin
      commit_valid_i = 1'b1;
      commit_id_i    = fid;
    end else if (r == 50) begin
      do uid = IDW'($urandom_range(0, 15)); while (id_live(uid) || uid == fid);
      commit_valid_i = 1'b1;
      commit_id_i    = uid;
    end
    out_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    rst_ni        = 1'b0;
    issue_id_i    = '0;
    issue_instr_i = '0;
    issue_rs_i    = '0;
    commit_id_i   = '0;
    set_idle();
    model_reset();
    chk_en = 1'b1;
    tick();
    tick();
    rst_ni = 1'b1;
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_out_id", 64'(out_id_o), 64'd0);
    chk("rst_out_rs", out_rs_o, 64'd0);

    // Issue then commit next cycle
    drive_issue(4'd3);
    tick();
    issue_valid_i = 1'b0;
    drive_commit(4'd3, 1'b0);
    tick();
    commit_valid_i = 1'b0;
    chk("t1_out_valid", 64'(out_valid_o), 64'd1);
    chk("t1_out_id", 64'(out_id_o), 64'd3);
    chk("t1_count", 64'(count_o), 64'd1);
    chk("t1_model_count", 64'(mq.size()), 64'd1);
    tick();
    chk("t1_count_after_pop", 64'(count_o), 64'd0);

    // Fill, then free one slot
    for (int i = 0; i < 4; i++) begin
      drive_issue(IDW'(i));
      tick();
    end
    issue_valid_i = 1'b0;
    chk("t2_full_count", 64'(count_o), 64'd4);
    chk("t2_full_ready", 64'(issue_ready_o), 64'd0);
    chk("t2_model_full", 64'(mq.size()), 64'd4);
    drive_commit(4'd0, 1'b0);
    tick();
    commit_valid_i = 1'b0;
    chk("t2_ready_during_pop", 64'(issue_ready_o), 64'd0);
    chk("t2_head_valid", 64'(out_valid_o), 64'd1);
    tick();
    chk("t2_ready_after_pop", 64'(issue_ready_o), 64'd1);
    chk("t2_count_after_pop", 64'(count_o), 64'd3);
    for (int i = 1; i < 4; i++) begin
      drive_commit(IDW'(i), 1'b0);
      tick();
    end
    commit_valid_i = 1'b0;
    tick();
    tick();
    chk("t2_drained", 64'(count_o), 64'd0);

    // Out-of-order commits
    drive_issue(4'd1);
    tick();
    drive_issue(4'd2);
    tick();
    issue_valid_i = 1'b0;
    drive_commit(4'd2, 1'b0);
    tick();
    chk("t3_head_blocked", 64'(out_valid_o), 64'd0);
    drive_commit(4'd1, 1'b0);
    tick();
    commit_valid_i = 1'b0;
    chk("t3_first_id", 64'(out_id_o), 64'd1);
    tick();
    chk("t3_second_valid", 64'(out_valid_o), 64'd1);
    chk("t3_second_id", 64'(out_id_o), 64'd2);
    tick();
    chk("t3_empty", 64'(count_o), 64'd0);

    // Kill the head
    drive_issue(4'd5);
    tick();
    drive_issue(4'd6);
    tick();
    issue_valid_i = 1'b0;
    drive_commit(4'd5, 1'b1);
    tick();
    chk("t4_killed_hidden", 64'(out_valid_o), 64'd0);
    chk("t4_count", 64'(count_o), 64'd2);
    drive_commit(4'd6, 1'b0);
    tick();
    commit_valid_i = 1'b0;
    chk("t4_next_valid", 64'(out_valid_o), 64'd1);
    chk("t4_next_id", 64'(out_id_o), 64'd6);
    chk("t4_count_after_kill", 64'(count_o), 64'd1);
    tick();

    // Same-cycle issue and commit, then a stray commit
    drive_issue(4'd7);
    drive_commit(4'd7, 1'b0);
    tick();
    issue_valid_i  = 1'b0;
    commit_valid_i = 1'b0;
    chk("t5_valid", 64'(out_valid_o), 64'd1);
    chk("t5_id", 64'(out_id_o), 64'd7);
    chk("t5_no_unexp", 64'(unexp_commit_o), 64'd0);
    tick();
    drive_commit(4'd9, 1'b0);
    tick();
    commit_valid_i = 1'b0;
    chk("t5_unexp", 64'(unexp_commit_o), 64'd1);
    tick();
    chk("t5_unexp_sticky", 64'(unexp_commit_o), 64'd1);

    // Stall the consumer, then reset mid-stream
    out_ready_i = 1'b0;
    drive_issue(4'd10);
    saved_instr = issue_instr_i;
    drive_commit(4'd10, 1'b0);
    tick();
    issue_valid_i  = 1'b0;
    commit_valid_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("t6_stall_valid", 64'(out_valid_o), 64'd1);
      chk("t6_stall_instr", 64'(out_instr_o), 64'(saved_instr));
      tick();
    end
    drive_issue(4'd11);
    tick();
    issue_valid_i = 1'b0;
    rst_ni = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_count", 64'(count_o), 64'd0);
    chk("t6_rst_valid", 64'(out_valid_o), 64'd0);
    chk("t6_rst_unexp", 64'(unexp_commit_o), 64'd0);
    chk("t6_rst_ready", 64'(issue_ready_o), 64'd0);
    tick();
    tick();
    rst_ni = 1'b1;
    set_idle();
    tick();
    chk("t6_post_rst_valid", 64'(out_valid_o), 64'd0);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      rand_drive();
      tick();
    end
    set_idle();
    repeat (8) tick();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
